nes_pad_reader: RTL
===================

# nes_pad_reader

Serial front end for the standard 8-button game pad. It produces the `controller_data[7:0]` bus that the CPU datapath samples for controller loads. The block periodically latches the pad, clocks out 8 serial bits, and presents a registered, active-high button byte plus a one-cycle update strobe and a newly-pressed mask. It sits between the board pad connector and the datapath's controller input.

## Interface
- `CLK_DIV`, default 300: `clk` cycles per half-period of `pad_clk`. Also half the latch width. Legal minimum is 1.
- `POLL_CYCLES`, default 833333: `clk` cycles between automatic polls (60 Hz at 50 MHz). Must be greater than 16*`CLK_DIV`.
- `clk`, input, 1: system clock. This is the only clock in the block.
- `reset`, input, 1: synchronous, active-high reset.
- `poll_req`, input, 1: requests an immediate poll. Honoured only in IDLE.
- `pad_data`, input, 1: serial data from the pad. Asynchronous and active-low (0 = pressed).
- `pad_latch`, output, 1: latch strobe to the pad, active-high.
- `pad_clk`, output, 1: shift clock to the pad. Idles high.
- `controller_data`, output, 8: button state, 1 = pressed. Bit 0 = A, 1 = B, 2 = Select, 3 = Start, 4 = Up, 5 = Down, 6 = Left, 7 = Right.
- `pressed`, output, 8: buttons newly pressed in this update, equal to new & ~old. Valid only while `data_valid` = 1; otherwise 0.
- `data_valid`, output, 1: one-cycle strobe that marks a `controller_data` update.
- `busy`, output, 1: high in every state except IDLE.

## Operation
- `pad_data` passes through a 2-flop synchronizer before any use. All sampling uses the synchronized value.
- The FSM has four states: IDLE, LATCH, CLK_LO, CLK_HI.
- IDLE:
  - `pad_latch` = 0, `pad_clk` = 1.
  - The poll timer counts down from `POLL_CYCLES`-1.
  - Enter LATCH when the timer reaches 0 or `poll_req` = 1. On entry, reload the timer and clear the bit index k to 0.
- LATCH:
  - `pad_latch` = 1 for 2*`CLK_DIV` cycles.
  - On the last cycle, sample bit 0, set k = 1, and go to CLK_LO.
- CLK_LO: `pad_clk` = 0 for `CLK_DIV` cycles, then go to CLK_HI.
- CLK_HI:
  - `pad_clk` = 1 for `CLK_DIV` cycles. The pad shifts on the rising edge.
  - On the last cycle, sample bit k.
  - If k < 7, increment k and go to CLK_LO.
  - If k = 7, go to IDLE and commit the frame.
- Commit, registered on the cycle after the final sample:
  - new = ~raw
  - `pressed` = new & ~`controller_data`
  - `controller_data` = new
  - `data_valid` = 1 for one cycle.
- The poll timer does not count in non-IDLE states. It resumes counting on the first IDLE cycle.
- If `poll_req` and timer expiry occur together, one poll starts.
- `poll_req` is ignored while `busy` = 1. It is not queued.
- Reset mid-frame aborts the frame with no commit. `controller_data` is cleared and the FSM returns to IDLE.
- Reset values:
  - `pad_latch` = 0, `pad_clk` = 1
  - `controller_data` = 0, `pressed` = 0, `data_valid` = 0, `busy` = 0
  - FSM in IDLE, timer = `POLL_CYCLES`-1, synchronizer flops = 1, raw shift register = 8'hFF.

## Timing
- Cycle 0 is the first LATCH cycle (`busy` rises here).
- The frame occupies cycles 0 through 16*`CLK_DIV`-1.
- Bit 0 is sampled at cycle 2*`CLK_DIV`-1.
- Bit k (k = 1..7) is sampled at cycle (2k+2)*`CLK_DIV`-1.
- `data_valid` and the new `controller_data` appear at cycle 16*`CLK_DIV`. `busy` = 0 on that same cycle.
- Input latency: a change on `pad_data` becomes visible to the sampler 2 cycles later. Pads must hold data stable for at least 3 cycles before each sample point.
- With no `poll_req`, automatic polls start every `POLL_CYCLES` + 16*`CLK_DIV` cycles.

## Configuration
- `NES_PAD_DEBOUNCE_EN` defined:
  - The block keeps the previous frame's raw byte.
  - Commit (`controller_data`, `pressed`, `data_valid`) happens only when the current raw byte equals the previous raw byte.
  - The previous raw byte always updates.
  - The previous raw byte resets to 8'hFF.
- `NES_PAD_DEBOUNCE_EN` not defined: every completed frame commits.

## Test plan
All scenarios use `CLK_DIV` = 4 and `POLL_CYCLES` = 200.
- Reset, then idle: check the reset values. The first `pad_latch` rises at cycle 200 after reset release. `pad_latch` stays high for 8 cycles. `pad_clk` shows exactly 7 low pulses of 4 cycles each.
- Pad model with A and Right pressed (serial 0,1,1,1,1,1,1,0): `data_valid` pulses at cycle 64 after latch start, with `controller_data` = 8'h81 and `pressed` = 8'h81. The next identical frame gives `controller_data` = 8'h81 and `pressed` = 8'h00.
- `poll_req` pulsed in IDLE at timer = 150: latch starts on the next cycle and the timer reloads. A second `poll_req` at frame cycle 20 is ignored, giving a single `data_valid`.
- Reset asserted at frame cycle 30: on the next cycle, state is IDLE, `pad_clk` = 1, `controller_data` = 0, and no `data_valid` occurs.
- With `NES_PAD_DEBOUNCE_EN`: frames 8'h01, 8'h03, 8'h03 (pressed values) produce no commit on frames 1 and 2. Frame 3 commits `controller_data` = 8'h03.
- Without the macro, the same stimulus produces three `data_valid` pulses with values 8'h01, 8'h03, 8'h03.

Source files
------------

// File: rtl/nes_pad_reader.sv
// Serial reader for an 8-button game pad: latch, shift, commit a byte.
// Define NES_PAD_DEBOUNCE_EN to commit only when two frames match.
module nes_pad_reader #(
  parameter int CLK_DIV     = 300,
  parameter int POLL_CYCLES = 833333
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       poll_req,
  input  logic       pad_data,
  output logic       pad_latch,
  output logic       pad_clk,
  output logic [7:0] controller_data,
  output logic [7:0] pressed,
  output logic       data_valid,
  output logic       busy
);

  localparam int CW = $clog2(2 * CLK_DIV + 1);
  localparam int TW = $clog2(POLL_CYCLES + 1);
  localparam logic [CW-1:0] LAT_END = CW'(2 * CLK_DIV - 1);
  localparam logic [CW-1:0] PH_END  = CW'(CLK_DIV - 1);
  localparam logic [TW-1:0] T_LOAD  = TW'(POLL_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LATCH,
    S_CLK_LO,
    S_CLK_HI
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      k_q;
  logic [TW-1:0]   timer_q;
  logic [7:0]      raw_q;
  logic [7:0]      raw_d;
  logic            sync1_q;
  logic            sync2_q;
  logic            latch_q;
  logic            pclk_q;
  logic            busy_q;
  logic            valid_q;
  logic [7:0]      data_q;
  logic [7:0]      pressed_q;
  logic            commit_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= pad_data;
      sync2_q <= sync1_q;
    end
  end

  // Raw byte with the bit currently being sampled merged in.
  always_comb begin
    raw_d = raw_q;
    raw_d[k_q] = sync2_q;
  end

`ifdef NES_PAD_DEBOUNCE_EN
  logic [7:0] prev_q;
  assign commit_ok = (raw_d == prev_q);
`else
  assign commit_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      k_q       <= '0;
      timer_q   <= T_LOAD;
      raw_q     <= 8'hFF;
      latch_q   <= 1'b0;
      pclk_q    <= 1'b1;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      data_q    <= 8'h00;
      pressed_q <= 8'h00;
`ifdef NES_PAD_DEBOUNCE_EN
      prev_q    <= 8'hFF;
`endif
    end else begin
      valid_q   <= 1'b0;
      pressed_q <= 8'h00;
      unique case (state_q)
        S_IDLE: begin
          if (timer_q == '0 || poll_req) begin
            state_q <= S_LATCH;
            timer_q <= T_LOAD;
            k_q     <= '0;
            cnt_q   <= '0;
            latch_q <= 1'b1;
            busy_q  <= 1'b1;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        S_LATCH: begin
          if (cnt_q == LAT_END) begin
            raw_q   <= raw_d;
            k_q     <= 3'd1;
            cnt_q   <= '0;
            latch_q <= 1'b0;
            pclk_q  <= 1'b0;
            state_q <= S_CLK_LO;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_CLK_LO: begin
          if (cnt_q == PH_END) begin
            cnt_q   <= '0;
            pclk_q  <= 1'b1;
            state_q <= S_CLK_HI;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_CLK_HI: begin
          if (cnt_q == PH_END) begin
            cnt_q <= '0;
            raw_q <= raw_d;
            if (k_q == 3'd7) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              if (commit_ok) begin
                data_q    <= ~raw_d;
                pressed_q <= ~raw_d & ~data_q;
                valid_q   <= 1'b1;
              end
`ifdef NES_PAD_DEBOUNCE_EN
              prev_q <= raw_d;
`endif
            end else begin
              k_q     <= k_q + 1'b1;
              pclk_q  <= 1'b0;
              state_q <= S_CLK_LO;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign pad_latch       = latch_q;
  assign pad_clk         = pclk_q;
  assign busy            = busy_q;
  assign data_valid      = valid_q;
  assign controller_data = data_q;
  assign pressed         = pressed_q;

endmodule
